result_rr_arbiter: RTL and testbench
====================================

Name: result_rr_arbiter

Overview:
Round-robin arbiter that sits directly upstream of mux_1OfN and drives its select input. It picks one of 2**NUM_PORTS_WIDTH result lanes, holds select stable while the mux registers that lane's data, and presents a valid/ready handshake aligned with the mux's registered data_out. It acknowledges the lane back only when the downstream consumer accepts the item.

Parameters:
NUM_PORTS_WIDTH, 2, log2 of lane count; must match the paired mux_1OfN.
NUM_PORTS, 2**NUM_PORTS_WIDTH, derived localparam; not overridable.

Ports:
clk  in  1  single clock; shared with mux_1OfN.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  NUM_PORTS  per-lane request; lane data sits on mux data_in.
in_ready  out  NUM_PORTS  per-lane one-cycle acknowledge.
mux_select  out  NUM_PORTS_WIDTH  registered; drives mux_1OfN.select.
out_valid  out  1  mux data_out holds an accepted lane item.
out_port  out  NUM_PORTS_WIDTH  lane index of the current out item.
out_ready  in  1  downstream accepts (out_valid & out_ready = transfer).

Behaviour:
- Reset (async assert, sync release): state=IDLE, mux_select=0, out_valid=0, out_port=0, in_ready=0, last_grant=NUM_PORTS-1, so lane 0 has first priority.
- Lane rule: once in_valid[i]=1, the lane holds in_valid and its data until in_ready[i]=1. The arbiter never samples data itself; the mux recaptures each cycle, so a stall is safe.
- Priority: rotating. Search starts at (last_grant+1) mod NUM_PORTS and picks the first lane with in_valid=1. Wrap-around is required (e.g. last_grant=3, N=4 → search order 0,1,2,3).
- FSM:
  - IDLE: if any in_valid → mux_select<=winner, last_grant<=winner, go to ARM. Otherwise stay.
  - ARM (1 cycle; mux captures data_in[mux_select] at this cycle's edge): out_valid<=1, out_port<=mux_select, go to PRESENT.
  - PRESENT: out_valid=1; mux_select held.
    - out_ready=0 → stay; no output changes.
    - out_ready=1 → in_ready[out_port]=1 (combinational, this cycle only), out_valid<=0.
      - Re-arbitrate in the same cycle with lane out_port masked. If another winner exists → mux_select<=winner, go to ARM. Else → IDLE.
- in_ready is combinational: in_ready[i] = (state==PRESENT) & out_ready & (out_port==i). It is never asserted in any other state.
- Latency: request seen in IDLE at cycle t → out_valid at t+2. Sustained throughput is 1 item per 2 cycles: the bubble is the ARM cycle.
- Masking: the just-acked lane cannot win in the handshake cycle, even if it is the only requester. It re-enters from IDLE next cycle with lowest priority, so starvation is impossible.
- A requester arriving during ARM/PRESENT waits; no preemption.
- in_valid[mux_select] dropping in ARM/PRESENT is a protocol violation: the item is still presented, and the behaviour is undefined beyond holding the FSM legal.
- Reset mid-operation: the pending item is discarded without ack. The lane still holds valid and is re-arbitrated after release.

Optional Feature:
RESULT_RR_ARBITER_STALL_CNT_EN
- Defined: adds output stall_cnt [31:0]. It increments (saturating at 2**32-1) each cycle in PRESENT with out_ready=0, and resets to 0 on rst_n.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package darwin_arb_pkg:
  - state enum (IDLE, ARM, PRESENT)
  - NUM_PORTS derivation function
  - stall counter width constant (32)
- One combinational sub-module rr_priority_pick:
  - Inputs: request vector, mask vector, last_grant.
  - Outputs: found, winner index.
  - Reused for the IDLE and handshake-cycle picks.

Test Plan:
- Reset, then in_valid=4'b0001, out_ready=1 → mux_select=0 at t+1; out_valid=1, out_port=0 at t+2; in_ready=4'b0001 on that cycle; mux data_out equals lane 0 data.
- All lanes valid continuously, out_ready=1 → out_port sequence 0,1,2,3,0; out_valid toggles 1-0-1-0 (1 item per 2 cycles); exactly one in_ready pulse per item.
- Lane 2 only, valid continuously → lane 2 served, FSM returns to IDLE for one cycle between items; every item is ack'd, none duplicated.
- out_valid=1, out_port=1, out_ready held 0 for 5 cycles → mux_select stays 1, in_ready stays 0000, data_out stable; with STALL_CNT_EN, stall_cnt=5.
- rst_n asserted while in PRESENT with port 3 pending → out_valid=0 and mux_select=0 immediately (async); after release, port 3 (still valid) is served; lanes 0..2 keep priority order from last_grant=3.
- last_grant=3, in_valid=4'b1001 at the handshake of port 3 → winner 0 (wrap-around, port 3 masked).

Source files
------------

// File: rtl/darwin_arb_pkg.sv
// Shared types and constants for the result round-robin arbiter.
package darwin_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    PRESENT = 2'd2
  } arb_state_e;

  localparam int STALL_CNT_W = 32;

  function automatic int num_ports(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority pick: first unmasked requester after last_grant.
module rr_priority_pick
  import darwin_arb_pkg::*;
#(
  parameter  int NUM_PORTS_WIDTH = 2,
  localparam int NUM_PORTS       = num_ports(NUM_PORTS_WIDTH)
) (
  input  logic [NUM_PORTS-1:0]       req,
  input  logic [NUM_PORTS-1:0]       mask,
  input  logic [NUM_PORTS_WIDTH-1:0] last_grant,
  output logic                       found,
  output logic [NUM_PORTS_WIDTH-1:0] winner
);

  logic [NUM_PORTS-1:0]       avail;
  logic [NUM_PORTS_WIDTH-1:0] idx;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    avail  = req & ~mask;
    // Offsets 1..NUM_PORTS wrap through the index width; the last offset is last_grant itself.
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = last_grant + NUM_PORTS_WIDTH'(k);
      if (!found && avail[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/result_rr_arbiter.sv
// Round-robin arbiter driving mux_1OfN.select with a valid/ready output handshake.
// Optional stall counter output enabled by RESULT_RR_ARBITER_STALL_CNT_EN.
module result_rr_arbiter
  import darwin_arb_pkg::*;
#(
  parameter  int NUM_PORTS_WIDTH = 2,
  localparam int NUM_PORTS       = num_ports(NUM_PORTS_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PORTS-1:0]       in_valid,
  output logic [NUM_PORTS-1:0]       in_ready,
  output logic [NUM_PORTS_WIDTH-1:0] mux_select,
  output logic                       out_valid,
  output logic [NUM_PORTS_WIDTH-1:0] out_port,
  input  logic                       out_ready
`ifdef RESULT_RR_ARBITER_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]     stall_cnt
`endif
);

  arb_state_e                 state_q, state_d;
  logic [NUM_PORTS_WIDTH-1:0] mux_select_q, mux_select_d;
  logic [NUM_PORTS_WIDTH-1:0] last_grant_q, last_grant_d;
  logic                       out_valid_q, out_valid_d;
  logic [NUM_PORTS_WIDTH-1:0] out_port_q, out_port_d;

  logic [NUM_PORTS-1:0]       pick_mask;
  logic                       pick_found;
  logic [NUM_PORTS_WIDTH-1:0] pick_winner;
  logic                       handshake;

  assign handshake = (state_q == PRESENT) && out_ready;

  // One picker serves both IDLE and handshake-cycle arbitration; only the acked lane is masked.
  assign pick_mask = (state_q == PRESENT) ? (NUM_PORTS'(1) << out_port_q) : '0;

  rr_priority_pick #(
    .NUM_PORTS_WIDTH(NUM_PORTS_WIDTH)
  ) u_pick (
    .req       (in_valid),
    .mask      (pick_mask),
    .last_grant(last_grant_q),
    .found     (pick_found),
    .winner    (pick_winner)
  );

  always_comb begin
    state_d      = state_q;
    mux_select_d = mux_select_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_port_d   = out_port_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          mux_select_d = pick_winner;
          last_grant_d = pick_winner;
          state_d      = ARM;
        end
      end
      ARM: begin
        out_valid_d = 1'b1;
        out_port_d  = mux_select_q;
        state_d     = PRESENT;
      end
      PRESENT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (pick_found) begin
            mux_select_d = pick_winner;
            last_grant_d = pick_winner;
            state_d      = ARM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mux_select_q <= '0;
      last_grant_q <= NUM_PORTS_WIDTH'(NUM_PORTS - 1);
      out_valid_q  <= 1'b0;
      out_port_q   <= '0;
    end else begin
      state_q      <= state_d;
      mux_select_q <= mux_select_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_port_q   <= out_port_d;
    end
  end

  assign in_ready   = handshake ? (NUM_PORTS'(1) << out_port_q) : '0;
  assign mux_select = mux_select_q;
  assign out_valid  = out_valid_q;
  assign out_port   = out_port_q;

`ifdef RESULT_RR_ARBITER_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == PRESENT) && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_result_rr_arbiter.sv
// Directed self-checking bench for result_rr_arbiter with a behavioural registered mux alongside.
module tb_result_rr_arbiter;
  import darwin_arb_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [1:0] mux_select;
  logic       out_valid;
  logic [1:0] out_port;
  logic       out_ready;
`ifdef RESULT_RR_ARBITER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  logic [7:0] lane_data [4];
  logic [7:0] mux_data_q;

  int n_checks = 0;
  int n_fail   = 0;

  result_rr_arbiter #(.NUM_PORTS_WIDTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mux_select(mux_select),
    .out_valid (out_valid),
    .out_port  (out_port),
    .out_ready (out_ready)
`ifdef RESULT_RR_ARBITER_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for mux_1OfN: recaptures the selected lane every edge.
  always @(posedge clk) mux_data_q <= lane_data[mux_select];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    lane_data[0] = 8'hA0;
    lane_data[1] = 8'hB1;
    lane_data[2] = 8'hC2;
    lane_data[3] = 8'hD3;

    // Reset state
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mux_select", 32'(mux_select), 32'd0);
    check("rst_out_port", 32'(out_port), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef RESULT_RR_ARBITER_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 32'd0);
`endif

    // Single lane 0 request: select at t+1, presented at t+2
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    tick();
    check("t1_arm_sel", 32'(mux_select), 32'd0);
    check("t1_arm_valid", 32'(out_valid), 32'd0);
    tick();
    check("t1_pres_valid", 32'(out_valid), 32'd1);
    check("t1_pres_port", 32'(out_port), 32'd0);
    check("t1_pres_ready", 32'(in_ready), 32'b0001);
    check("t1_pres_data", 32'(mux_data_q), 32'hA0);
    tick();
    in_valid = 4'b0000;
    check("t1_done_valid", 32'(out_valid), 32'd0);
    check("t1_done_ready", 32'(in_ready), 32'd0);

    // All lanes valid: ports 0,1,2,3,0 one item per two cycles
    do_reset();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int exp_port;
      exp_port = k % 4;
      tick();
      check("t2_arm_sel", 32'(mux_select), 32'(exp_port));
      check("t2_arm_valid", 32'(out_valid), 32'd0);
      check("t2_arm_ready", 32'(in_ready), 32'd0);
      tick();
      check("t2_pres_valid", 32'(out_valid), 32'd1);
      check("t2_pres_port", 32'(out_port), 32'(exp_port));
      check("t2_pres_ready", 32'(in_ready), 32'(4'b0001 << exp_port));
      check("t2_pres_data", 32'(mux_data_q), 32'(lane_data[exp_port]));
    end

    // Lane 2 alone: ARM, PRESENT, IDLE repeating
    do_reset();
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t3_arm_sel", 32'(mux_select), 32'd2);
      check("t3_arm_valid", 32'(out_valid), 32'd0);
      tick();
      check("t3_pres_port", 32'(out_port), 32'd2);
      check("t3_pres_ready", 32'(in_ready), 32'b0100);
      tick();
      check("t3_idle_valid", 32'(out_valid), 32'd0);
      check("t3_idle_ready", 32'(in_ready), 32'd0);
    end

    // Stall on port 1 for five cycles
    do_reset();
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    tick();
    check("t4_arm_sel", 32'(mux_select), 32'd1);
    tick();
    check("t4_pres_port", 32'(out_port), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_stall_valid", 32'(out_valid), 32'd1);
      check("t4_stall_sel", 32'(mux_select), 32'd1);
      check("t4_stall_ready", 32'(in_ready), 32'd0);
      check("t4_stall_data", 32'(mux_data_q), 32'hB1);
    end
`ifdef RESULT_RR_ARBITER_STALL_CNT_EN
    check("t4_stall_cnt", stall_cnt, 32'd5);
`endif
    out_ready = 1'b1;
    #1;
    check("t4_release_ready", 32'(in_ready), 32'b0010);
    tick();
    check("t4_release_valid", 32'(out_valid), 32'd0);

    // Async reset while port 3 is presented
    do_reset();
    in_valid  = 4'b1000;
    out_ready = 1'b0;
    tick();
    check("t5_arm_sel", 32'(mux_select), 32'd3);
    tick();
    check("t5_pres_port", 32'(out_port), 32'd3);
    check("t5_pres_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'd0);
    check("t5_async_sel", 32'(mux_select), 32'd0);
    check("t5_async_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tick();
    check("t5_rearb_sel", 32'(mux_select), 32'd3);
    tick();
    check("t5_rearb_port", 32'(out_port), 32'd3);
    check("t5_rearb_ready", 32'(in_ready), 32'b1000);

    // Handshake of port 3 with lanes 0 and 3 requesting: wraps to lane 0
    in_valid = 4'b1001;
    tick();
    in_valid = 4'b0001;
    check("t6_wrap_sel", 32'(mux_select), 32'd0);
    check("t6_wrap_valid", 32'(out_valid), 32'd0);
    tick();
    check("t6_wrap_port", 32'(out_port), 32'd0);
    check("t6_wrap_ready", 32'(in_ready), 32'b0001);
    check("t6_wrap_data", 32'(mux_data_q), 32'hA0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
